// File: rtl/gated_byte_capture.sv
// gated_byte_capture: samples an enable-gated byte bus into a small
// first-word-fall-through FIFO and hands bytes downstream via valid/ready.
// Optional feature macro: GATED_BYTE_CAPTURE_CHECKSUM_EN adds chk_sum/chk_clr,
// a running XOR of accepted bytes.
module gated_byte_capture #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    bus_data,
  input  logic          bus_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overflow,
  input  logic          clr_ovf
`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
  ,
  output logic [7:0]    chk_sum,
  input  logic          chk_clr
`endif
);

  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push;
  logic          pop;
  logic          drop;

  // Status and fall-through read path, all derived from registered state
  assign rd_valid = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));
  assign pop      = rd_valid & rd_ready;
  assign push     = bus_en & (~full | pop);
  assign drop     = bus_en & full & ~pop;
  assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;
  assign count    = cnt;
  assign overflow = ovf;

  // Byte storage; contents need no reset because rd_data is masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
  logic [7:0] sum;

  // Running XOR of accepted bytes; a push alongside a clear restarts from that byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'h00;
    end else if (push) begin
      sum <= (chk_clr ? 8'h00 : sum) ^ bus_data;
    end else if (chk_clr) begin
      sum <= 8'h00;
    end
  end

  assign chk_sum = sum;
`endif

endmodule

// File: tb/tb_gated_byte_capture.sv
// Bench for gated_byte_capture: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_gated_byte_capture;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst_n;
  logic [7:0]    bus_data;
  logic          bus_en;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;
  logic          clr_ovf;
  logic          chk_clr;
`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
  logic [7:0]    chk_sum;
`endif

  int checks;
  int errors;

  gated_byte_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_data (bus_data),
    .bus_en   (bus_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
    ,
    .chk_sum  (chk_sum),
    .chk_clr  (chk_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a byte queue plus sticky flag and running XOR
  logic [7:0] q[$];
  logic       m_ovf;
  logic [7:0] m_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_sum = 8'h00;
    end else begin
      bit was_full, do_pop, do_push;
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() != 0) && rd_ready;
      do_push  = bus_en && (!was_full || do_pop);
      if (bus_en && was_full && !do_pop) m_ovf = 1'b1;
      else if (clr_ovf)                  m_ovf = 1'b0;
      if (chk_clr) m_sum = 8'h00;
      if (do_push) m_sum = m_sum ^ bus_data;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(bus_data);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("m_rd_valid", int'(rd_valid), int'(q.size() != 0));
    check("m_count",    int'(count),    q.size());
    check("m_full",     int'(full),     int'(q.size() == DEPTH));
    check("m_overflow", int'(overflow), int'(m_ovf));
    check("m_rd_data",  int'(rd_data),  (q.size() != 0) ? int'(q[0]) : 0);
`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
    check("m_chk_sum",  int'(chk_sum),  int'(m_sum));
`endif
  end

  // Apply one cycle of inputs shortly after the falling edge
  task automatic drive(input logic en, input logic [7:0] d, input logic rdy,
                       input logic co = 1'b0, input logic cc = 1'b0);
    @(negedge clk);
    #1;
    bus_en   = en;
    bus_data = d;
    rd_ready = rdy;
    clr_ovf  = co;
    chk_clr  = cc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus_en = 1'b0; bus_data = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0; chk_clr = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_en = 1'b0; bus_data = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0; chk_clr = 1'b0;
    do_reset();

    // 1: idle after reset, junk on the bus is ignored
    drive(1'b0, 8'h5A, 1'b0);
    drive(1'b0, 8'h5A, 1'b0);
    check("t1_rd_valid", int'(rd_valid), 0);
    check("t1_count",    int'(count),    0);
    check("t1_rd_data",  int'(rd_data),  0);
    check("t1_overflow", int'(overflow), 0);

    // 2: three pushes including a zero byte, then drain in order
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("t2_count3", int'(count), 3);
    drive(1'b0, 8'h00, 1'b1);
    check("t2_rd0", int'(rd_data), 8'h11);
    drive(1'b0, 8'h00, 1'b1);
    check("t2_rd1", int'(rd_data), 8'h22);
    drive(1'b0, 8'h00, 1'b1);
    check("t2_rd2", int'(rd_data), 8'h00);
    check("t2_valid2", int'(rd_valid), 1);
    drive(1'b0, 8'h00, 1'b0);
    check("t2_count0", int'(count), 0);

    // 3: overfill by one, last byte dropped
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hA1 + 8'(i), 1'b0);
    end
    check("t3_full", int'(full), 1);
    drive(1'b0, 8'h00, 1'b0);
    check("t3_overflow", int'(overflow), 1);
    check("t3_count", int'(count), 4);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      check("t3_drain", int'(rd_data), 8'hA1 + i);
    end
    drive(1'b0, 8'h00, 1'b0);
    check("t3_empty", int'(count), 0);
    check("t3_sticky", int'(overflow), 1);

    // 4: push and pop together while full
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hC1 + 8'(i), 1'b0);
    end
    drive(1'b1, 8'hB0, 1'b1);
    check("t4_full_before", int'(count), 4);
    drive(1'b0, 8'h00, 1'b0);
    check("t4_count", int'(count), 4);
    check("t4_no_ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      check("t4_drain", int'(rd_data), (i == 3) ? 8'hB0 : 8'hC2 + i);
    end

    // 5: streaming through the pointer wrap
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (i > 1) check("t5_stream", int'(rd_data), i - 1);
    end
    drive(1'b0, 8'h00, 1'b1);
    check("t5_last", int'(rd_data), 8'h0A);
    check("t5_no_ovf", int'(overflow), 0);
`ifdef GATED_BYTE_CAPTURE_CHECKSUM_EN
    check("t5_chk_sum", int'(chk_sum), 8'h0B);
`endif
    drive(1'b0, 8'h00, 1'b0);
    check("t5_empty", int'(count), 0);

    // 6: asynchronous reset while holding data
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hD0 + 8'(i), 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    check("t6_count3", int'(count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_count", int'(count), 0);
    check("t6_async_valid", int'(rd_valid), 0);
    check("t6_async_ovf",   int'(overflow), 0);
    #3;
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("t6_repush", int'(rd_data), 8'h77);
    check("t6_count1", int'(count), 1);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gated_byte_capture.md
Name: gated_byte_capture

Overview:
- Receive-side counterpart of the enable-gated 8-bit byte driver.
- Samples the gated 8-bit bus on every clock where the driver's enable is high and pushes the byte into a small FIFO.
- Presents buffered bytes to downstream logic over a valid/ready handshake.
- Sits between the gated-byte source and any consumer that cannot take a byte every cycle.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
AW, 2, pointer width; must equal log2(DEPTH).

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
bus_data  input  8  gated byte bus (0x00 when source enable is low)
bus_en  input  1  source enable; 1 = bus_data carries a valid byte this cycle
rd_data  output  8  head-of-FIFO byte
rd_valid  output  1  rd_data valid
rd_ready  input  1  consumer accepts rd_data this cycle
count  output  AW+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
overflow  output  1  sticky; a byte was dropped
clr_ovf  input  1  synchronous clear of overflow

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release on clk): pointers = 0, count = 0, rd_valid = 0, rd_data = 0x00, full = 0, overflow = 0. Storage contents are don't-care.
- Push: occurs at a rising edge where bus_en = 1 and (full = 0 or pop in the same cycle).
  - Captures bus_data at the write pointer.
  - Write pointer increments modulo DEPTH.
- A byte of 0x00 with bus_en = 1 is valid data and is stored. bus_data is ignored when bus_en = 0.
- Pop: occurs at a rising edge where rd_valid = 1 and rd_ready = 1. Read pointer increments modulo DEPTH.
- First-word fall-through:
  - rd_data is driven from the read pointer entry.
  - rd_valid = (count != 0).
  - rd_data = 0x00 when count = 0.
- Latency: a byte pushed at edge N is visible on rd_data/rd_valid after edge N (cycle N+1) when the FIFO was empty.
- count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither. full and rd_valid derive combinationally from registered count.
- Full, bus_en = 1, no pop: byte dropped, state unchanged, overflow set to 1 at that edge.
- Full, bus_en = 1, pop same edge: push accepted, count stays DEPTH, no overflow.
- Empty, bus_en = 1, rd_ready = 1: no pop (rd_valid = 0); push only, count becomes 1.
- overflow:
  - Remains 1 until clr_ovf = 1 at an edge.
  - If a drop and clr_ovf coincide, the drop wins and overflow stays 1.
- rd_ready while rd_valid = 0 has no effect.
- Reset asserted mid-stream: all buffered bytes are discarded immediately (outputs go to reset values asynchronously).
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0. Order is strictly FIFO across the wrap.

Optional Feature:
- Macro: GATED_BYTE_CAPTURE_CHECKSUM_EN.
- When defined:
  - Extra output chk_sum [7:0], an XOR of every byte accepted by a push since reset or since the last chk_clr.
  - Extra input chk_clr [0:0] (1 bit), which clears chk_sum to 0x00 at the edge.
  - Push and chk_clr at the same edge: chk_sum = pushed byte.
  - Dropped bytes are not included.
  - Reset value of chk_sum is 0x00.
- When undefined: ports chk_sum and chk_clr do not exist, and no checksum logic is present.

Test Plan:
1. Reset then idle, bus_en = 0, bus_data = 0x5A -> rd_valid = 0, count = 0, rd_data = 0x00, overflow = 0.
2. Push 0x11, 0x22, 0x00 on consecutive cycles with rd_ready = 0 -> count = 3; then rd_ready = 1 for 3 cycles -> rd_data 0x11, 0x22, 0x00 in order; count = 0.
3. DEPTH = 4, push 0xA1..0xA5 with rd_ready = 0 -> full = 1 after the 4th push; 0xA5 dropped; overflow = 1; drain yields 0xA1..0xA4.
4. Full FIFO, bus_en = 1 with 0xB0 and rd_ready = 1 at the same edge -> count stays 4, overflow stays 0, and 0xB0 emerges last.
5. Stream 10 bytes 0x01..0x0A with rd_ready = 1 every cycle -> no drop, output sequence 0x01..0x0A across pointer wrap; with checksum enabled, chk_sum = 0x0B.
6. Three bytes buffered, rst_n pulsed low mid-cycle -> rd_valid and count drop to 0 before the next clk edge; overflow = 0; later pushes start at pointer 0.
